// File: rtl/morra_tabellone.sv
// morra_tabellone: match scoreboard for a two-player morra game.
// Counts manche results, ends a match by margin or by manche limit, and
// reports the final result. Optional PARTITA consistency checker is compiled
// only when the MORRA_CHECK_EN macro is defined.
module morra_tabellone #(
  parameter int unsigned MIN_MANCHE = 4,
  parameter int unsigned MAX_MANCHE = 16,
  parameter int unsigned MARGIN     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INIZIA,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic [4:0] PUNTI_PRIMO,
  output logic [4:0] PUNTI_SECONDO,
  output logic [4:0] PAREGGI,
  output logic [4:0] GIOCATE,
  output logic [1:0] ESITO,
  output logic [1:0] STATO,
  output logic       FINE_P
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGioco  = 2'b01,
    StFine   = 2'b10,
    StErrore = 2'b11
  } stato_e;

  localparam logic [4:0] LpMin    = 5'(MIN_MANCHE);
  localparam logic [4:0] LpMax    = 5'(MAX_MANCHE);
  localparam logic [5:0] LpMargin = 6'(MARGIN);

  stato_e      r_stato, w_stato_d;
  logic [4:0]  r_p1, r_p2, r_par, r_gio;
  logic [4:0]  w_p1_d, w_p2_d, w_par_d, w_gio_d;
  logic [4:0]  w_n_p1, w_n_p2, w_n_par, w_n_gio;
  logic [1:0]  r_esito, w_esito_d;
  logic        r_fine_p, w_fine_p_d;
  logic        w_valid;
  logic signed [5:0] w_diff;
  logic [5:0]  w_abs;
  logic [1:0]  w_leader;
  logic        w_end;
  logic        w_mismatch;

  // Post-increment counter values and end-of-match evaluation
  always_comb begin
    w_valid  = (MANCHE != 2'b00);
    w_n_p1   = r_p1  + {4'b0, MANCHE == 2'b01};
    w_n_p2   = r_p2  + {4'b0, MANCHE == 2'b10};
    w_n_par  = r_par + {4'b0, MANCHE == 2'b11};
    w_n_gio  = r_gio + {4'b0, w_valid};
    w_diff   = $signed({1'b0, w_n_p1}) - $signed({1'b0, w_n_p2});
    w_abs    = w_diff[5] ? 6'(-w_diff) : 6'(w_diff);
    w_leader = w_diff[5] ? 2'b10 : ((w_diff == 6'sd0) ? 2'b11 : 2'b01);
    w_end    = w_valid && (((w_n_gio >= LpMin) && (w_abs >= LpMargin)) || (w_n_gio == LpMax));
  end

`ifdef MORRA_CHECK_EN
  // Engine status must read 00 while running and the final result on the ending edge
  always_comb begin
    w_mismatch = (PARTITA != (w_end ? w_leader : 2'b00));
  end
`else
  logic w_unused_partita;
  assign w_unused_partita = ^PARTITA;
  assign w_mismatch       = 1'b0;
`endif

  // Next-state and next-counter logic; INIZIA overrides everything else
  always_comb begin
    w_stato_d  = r_stato;
    w_p1_d     = r_p1;
    w_p2_d     = r_p2;
    w_par_d    = r_par;
    w_gio_d    = r_gio;
    w_esito_d  = r_esito;
    w_fine_p_d = 1'b0;
    if (INIZIA) begin
      w_stato_d = StGioco;
      w_p1_d    = '0;
      w_p2_d    = '0;
      w_par_d   = '0;
      w_gio_d   = '0;
      w_esito_d = 2'b00;
    end else if (r_stato == StGioco) begin
      if (w_valid && (r_gio == LpMax)) begin
        // Overflow guard: counters hold rather than wrap
        w_stato_d = StErrore;
      end else begin
        if (w_valid) begin
          w_p1_d  = w_n_p1;
          w_p2_d  = w_n_p2;
          w_par_d = w_n_par;
          w_gio_d = w_n_gio;
        end
        if (w_mismatch) begin
          w_stato_d = StErrore;
        end else if (w_end) begin
          w_stato_d  = StFine;
          w_esito_d  = w_leader;
          w_fine_p_d = 1'b1;
        end
      end
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stato  <= StIdle;
      r_p1     <= '0;
      r_p2     <= '0;
      r_par    <= '0;
      r_gio    <= '0;
      r_esito  <= 2'b00;
      r_fine_p <= 1'b0;
    end else begin
      r_stato  <= w_stato_d;
      r_p1     <= w_p1_d;
      r_p2     <= w_p2_d;
      r_par    <= w_par_d;
      r_gio    <= w_gio_d;
      r_esito  <= w_esito_d;
      r_fine_p <= w_fine_p_d;
    end
  end

  assign PUNTI_PRIMO   = r_p1;
  assign PUNTI_SECONDO = r_p2;
  assign PAREGGI       = r_par;
  assign GIOCATE       = r_gio;
  assign ESITO         = r_esito;
  assign STATO         = r_stato;
  assign FINE_P        = r_fine_p;

endmodule

// File: tb/tb_morra_tabellone.sv
// Self-checking bench for morra_tabellone: directed scenarios plus random
// stimulus compared every cycle against a behavioural scoreboard model.
module tb_morra_tabellone;

  localparam int MinM = 4;
  localparam int MaxM = 16;
  localparam int Marg = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       INIZIA;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;
  logic [4:0] PUNTI_PRIMO, PUNTI_SECONDO, PAREGGI, GIOCATE;
  logic [1:0] ESITO, STATO;
  logic       FINE_P;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain integers, 0 idle, 1 playing, 2 finished, 3 error
  int m_st = 0, m_p1 = 0, m_p2 = 0, m_par = 0, m_gio = 0, m_es = 0, m_fp = 0;

  morra_tabellone #(
    .MIN_MANCHE(MinM),
    .MAX_MANCHE(MaxM),
    .MARGIN    (Marg)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .INIZIA       (INIZIA),
    .MANCHE       (MANCHE),
    .PARTITA      (PARTITA),
    .PUNTI_PRIMO  (PUNTI_PRIMO),
    .PUNTI_SECONDO(PUNTI_SECONDO),
    .PAREGGI      (PAREGGI),
    .GIOCATE      (GIOCATE),
    .ESITO        (ESITO),
    .STATO        (STATO),
    .FINE_P       (FINE_P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_par = 0; m_gio = 0; m_es = 0; m_fp = 0;
  endtask

  task automatic model_edge(input bit r, input bit ini, input int man, input int par);
    int d, ad, status;
    bit ending, bad;
    if (r) begin
      model_clear();
      m_st = 0;
    end else if (ini) begin
      model_clear();
      m_st = 1;
    end else begin
      m_fp = 0;
      if (m_st == 1) begin
        if (man != 0 && m_gio == MaxM) begin
          m_st = 3;
        end else begin
          status = 0;
          ending = 1'b0;
          if (man != 0) begin
            if (man == 1) m_p1++;
            else if (man == 2) m_p2++;
            else m_par++;
            m_gio++;
            d  = m_p1 - m_p2;
            ad = (d < 0) ? -d : d;
            ending = ((m_gio >= MinM) && (ad >= Marg)) || (m_gio == MaxM);
            if (ending) status = (d > 0) ? 1 : ((d < 0) ? 2 : 3);
          end
          bad = 1'b0;
`ifdef MORRA_CHECK_EN
          bad = (par != status);
`endif
          if (bad) begin
            m_st = 3;
          end else if (ending) begin
            m_st = 2;
            m_es = status;
            m_fp = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("stato", int'(STATO), m_st);
    chk("p1", int'(PUNTI_PRIMO), m_p1);
    chk("p2", int'(PUNTI_SECONDO), m_p2);
    chk("pareggi", int'(PAREGGI), m_par);
    chk("giocate", int'(GIOCATE), m_gio);
    chk("esito", int'(ESITO), m_es);
    chk("fine_p", int'(FINE_P), m_fp);
  endtask

  // One clock: drive, take the edge, advance the model, sample 1ns later
  task automatic step(input bit r, input bit ini, input logic [1:0] man,
                      input logic [1:0] par);
    rst = r; INIZIA = ini; MANCHE = man; PARTITA = par;
    @(posedge clk);
    model_edge(r, ini, int'(man), int'(par));
    #1;
    check_all();
  endtask

  int fp_count;
  logic [1:0] seq;

  initial begin
    rst = 1'b1; INIZIA = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00;

    // Reset state
    step(1, 0, 2'b00, 2'b00);
    chk("rst_stato", int'(STATO), 0);
    chk("rst_fine_p", int'(FINE_P), 0);

    // Win by margin: 01,01,11,01
    step(0, 1, 2'b00, 2'b00);
    chk("start_stato", int'(STATO), 1);
    step(0, 0, 2'b01, 2'b00);
    step(0, 0, 2'b01, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    step(0, 0, 2'b01, 2'b01);
    chk("m1_p1", int'(PUNTI_PRIMO), 3);
    chk("m1_par", int'(PAREGGI), 1);
    chk("m1_gio", int'(GIOCATE), 4);
    chk("m1_esito", int'(ESITO), 1);
    chk("m1_stato", int'(STATO), 2);
    fp_count = int'(FINE_P);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b10, 2'b00);
      fp_count += int'(FINE_P);
    end
    chk("m1_fp_once", fp_count, 1);
    chk("m1_esito_hold", int'(ESITO), 1);

    // 16 alternating manches end in a draw at the limit
    step(0, 1, 2'b00, 2'b00);
    for (int i = 0; i < 16; i++) begin
      seq = (i % 2 == 0) ? 2'b01 : 2'b10;
      step(0, 0, seq, (i == 15) ? 2'b11 : 2'b00);
    end
    chk("m2_gio", int'(GIOCATE), 16);
    chk("m2_esito", int'(ESITO), 3);
    chk("m2_stato", int'(STATO), 2);
    step(0, 0, 2'b01, 2'b00);
    chk("m2_17th_p1", int'(PUNTI_PRIMO), 8);
    chk("m2_17th_gio", int'(GIOCATE), 16);

    // INIZIA wins over MANCHE on the same edge
    step(0, 1, 2'b01, 2'b00);
    chk("m3_p1", int'(PUNTI_PRIMO), 0);
    chk("m3_gio", int'(GIOCATE), 0);
    chk("m3_stato", int'(STATO), 1);

    // Idle manche codes leave counters alone
    step(0, 0, 2'b01, 2'b00);
    step(0, 0, 2'b10, 2'b00);
    for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 2'b00);
    chk("m6_gio", int'(GIOCATE), 2);
    chk("m6_p1", int'(PUNTI_PRIMO), 1);

    // Reset mid-match after 3 manches
    step(0, 1, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b00);
    step(0, 0, 2'b10, 2'b00);
    step(0, 0, 2'b11, 2'b00);
    step(1, 0, 2'b01, 2'b00);
    chk("m4_stato", int'(STATO), 0);
    chk("m4_gio", int'(GIOCATE), 0);
    chk("m4_fine_p", int'(FINE_P), 0);
    step(0, 0, 2'b01, 2'b00);
    chk("m4_idle_gio", int'(GIOCATE), 0);

`ifdef MORRA_CHECK_EN
    // Inconsistent engine status forces the error state
    step(0, 1, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b00);
    step(0, 0, 2'b00, 2'b01);
    chk("m5_stato", int'(STATO), 3);
    step(0, 1, 2'b00, 2'b00);
    chk("m5_restart", int'(STATO), 1);
    chk("m5_gio", int'(GIOCATE), 0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit r, ini;
      logic [1:0] man, par;
      r   = ($urandom_range(0, 59) == 0);
      ini = ($urandom_range(0, 14) == 0);
      man = 2'($urandom_range(0, 3));
`ifdef MORRA_CHECK_EN
      par = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
`else
      par = 2'($urandom_range(0, 3));
`endif
      step(r, ini, man, par);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
